motor_cmd_arbiter: RTL
======================

MOTOR_CMD_ARBITER -- requirements
Module: motor_cmd_arbiter

Interface
REQ-001 SHALL have parameter DEADTIME_CYC, default 1000, cycles of forced coast between opposing direction codes.
REQ-002 SHALL have parameter RAMP_DIV, default 100, cycles per duty ramp tick.
REQ-003 SHALL have parameter RAMP_STEP, default 12'd250, maximum duty change per tick, per channel.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port estop  input  1  emergency stop, highest priority.
REQ-007 SHALL have port mis_req, mis_dir[3:0], mis_dutyA[11:0], mis_dutyB[11:0]  inputs  mission/servo requester, priority 2.
REQ-008 SHALL have port lf_req, lf_dir[3:0], lf_dutyA[11:0], lf_dutyB[11:0]  inputs  line-follow requester, priority 3 (lowest).
REQ-009 SHALL have port Direction  output  4  H-bridge inputs {IN1,IN2,IN3,IN4}.
REQ-010 SHALL have port DutyA, DutyB  output  12 each  PWM compare values to the PWM generators.
REQ-011 SHALL have port grant  output  2  00 none, 01 estop, 10 mission, 11 line-follow.
REQ-012 SHALL have port dir_err  output  1  one-cycle pulse on an illegal requested direction.

Function
REQ-013 SHALL pick the target each cycle by fixed priority estop > mis_req > lf_req; none active -> target Direction 0000, duty 0.
REQ-014 SHALL register grant one cycle after the request inputs change.
REQ-015 SHALL treat a requested direction with bits[3:2]==11 or bits[1:0]==11 as illegal: target becomes 0000/0, and dir_err pulses for one cycle, every cycle the illegal code is granted.
REQ-016 SHALL implement FSM states IDLE, RUN, DEAD, ESTOP.
REQ-017 IDLE: Direction 0000, duties 0; a nonzero legal target -> RUN, Direction applied next cycle, duties start from 0.
REQ-018 RUN: while target direction equals current Direction, duties ramp toward target.
REQ-019 RUN: a target direction of 0000 -> Direction 0000 and duties 0 next cycle, then IDLE.
REQ-020 RUN: a different nonzero target direction -> Direction 0000 and duties 0 next cycle, then DEAD.
REQ-021 DEAD: hold 0000/0 for exactly DEADTIME_CYC cycles, then IDLE; an IDLE entry with a nonzero target goes to RUN.
REQ-022 ESTOP: entered from any state the cycle after estop=1; Direction 0000 and duties 0 on that cycle.
REQ-023 ESTOP: on estop=0, go to DEAD (full dead time) before any motion.
REQ-024 Ramp: a free-running tick counter pulses once every RAMP_DIV cycles.
REQ-025 Ramp: on each tick in RUN, each duty moves toward its target by min(|target-current|, RAMP_STEP).
REQ-026 Ramp: duty never overshoots, never wraps below 0 or above 4095, and uses 13-bit intermediate arithmetic.
REQ-027 Ramp: a target duty decrease also ramps, unless REQ-019, REQ-020 or REQ-022 applies.
REQ-028 A grant change to a requester with the same direction SHALL continue the ramp from the current duties, with no dead time.
REQ-029 Simultaneous estop and any direction change: estop wins.
REQ-030 A requester dropping while in DEAD SHALL NOT shorten the dead time.

Reset
REQ-031 rst_n=0 at a clock edge: state IDLE, Direction 0000, DutyA/DutyB 0, grant 00, dir_err 0, and dead and ramp counters 0.
REQ-032 Reset mid-ramp or mid-dead SHALL abort immediately; no dead time is required after reset release.

Structure
REQ-033 SHALL place the direction codes FWD 0110, REV 1001, PIVL 0101, PIVR 1010, COAST 0000, the FSM state encoding and the grant encoding in the shared package rover_pkg.
REQ-034 SHALL instantiate the per-channel ramp limiter as sub-module duty_ramp.
REQ-035 duty_ramp SHALL take inputs clk, rst_n, tick, clear, target[11:0] and output duty[11:0].
REQ-036 motor_cmd_arbiter SHALL instantiate duty_ramp twice.

Verification
REQ-037 lf_req=1, lf_dir=0110, duties 4000/4000, RAMP_STEP=250 -> Direction 0110; duty reaches 4000 after 16 ticks, last step 250, no overshoot.
REQ-038 In RUN at 0110/3000, switch to lf_dir=1001 -> next cycle 0000/0; after 1000 cycles of 0000, 1001 applied and ramping from 0.
REQ-039 lf active, mis_req=1 with 0110/2000 -> grant 10 one cycle later; same direction, so no dead time and duty ramps down to 2000.
REQ-040 estop pulse mid-ramp -> 0000/0 the next cycle, grant 01; after release, 1000 dead cycles, then resume.
REQ-041 lf_dir=1100 -> dir_err pulses each granted cycle; Direction stays 0000.
REQ-042 rst_n=0 during DEAD -> all outputs 0 at the next edge; after release, a legal request is applied without dead time.

Source files
------------

// File: rtl/rover_pkg.sv
// Shared rover drive types: H-bridge direction codes,
// arbiter FSM states, grant codes and the command bundle.
package rover_pkg;

  localparam logic [3:0] DIR_COAST = 4'b0000;
  localparam logic [3:0] DIR_FWD   = 4'b0110;
  localparam logic [3:0] DIR_REV   = 4'b1001;
  localparam logic [3:0] DIR_PIVL  = 4'b0101;
  localparam logic [3:0] DIR_PIVR  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_ESTOP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_ESTOP = 2'b01,
    GNT_MIS   = 2'b10,
    GNT_LF    = 2'b11
  } grant_e;

  typedef struct packed {
    logic [3:0]  dir;
    logic [11:0] duty_a;
    logic [11:0] duty_b;
  } cmd_t;

  // Both legs of one bridge high would short the supply.
  function automatic logic dir_illegal(input logic [3:0] d);
    return (d[3:2] == 2'b11) || (d[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// Per-channel PWM duty slew limiter; moves at most STEP
// toward the target on each tick, clear forces zero.
module duty_ramp
  import rover_pkg::*;
#(
  parameter logic [11:0] STEP = 12'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        clear,
  input  logic [11:0] target,
  output logic [11:0] duty
);

  logic [11:0] duty_q;
  logic [11:0] duty_d;
  logic [12:0] diff;

  always_comb begin
    duty_d = duty_q;
    diff   = '0;
    if (clear) begin
      duty_d = '0;
    end else if (tick) begin
      if (target > duty_q) begin
        diff   = {1'b0, target} - {1'b0, duty_q};
        duty_d = (diff > {1'b0, STEP}) ? duty_q + STEP : target;
      end else begin
        diff   = {1'b0, duty_q} - {1'b0, target};
        duty_d = (diff > {1'b0, STEP}) ? duty_q - STEP : target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty = duty_q;

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Fixed-priority motor command arbiter with direction
// dead time, emergency stop and ramped PWM duties.
module motor_cmd_arbiter
  import rover_pkg::*;
#(
  parameter int          DEADTIME_CYC = 1000,
  parameter int          RAMP_DIV     = 100,
  parameter logic [11:0] RAMP_STEP    = 12'd250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        estop,
  input  logic        mis_req,
  input  logic [3:0]  mis_dir,
  input  logic [11:0] mis_dutyA,
  input  logic [11:0] mis_dutyB,
  input  logic        lf_req,
  input  logic [3:0]  lf_dir,
  input  logic [11:0] lf_dutyA,
  input  logic [11:0] lf_dutyB,
  output logic [3:0]  Direction,
  output logic [11:0] DutyA,
  output logic [11:0] DutyB,
  output logic [1:0]  grant,
  output logic        dir_err
);

  localparam int DW = $clog2(DEADTIME_CYC + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);

  state_e      state_q;
  logic [3:0]  dir_q;
  logic [DW-1:0] dead_q;
  logic [RW-1:0] rcnt_q;
  grant_e      grant_q;
  logic        err_q;

  cmd_t   req;
  cmd_t   tgt;
  grant_e gnt_d;
  logic   err_d;
  logic   tick;
  logic   hold;

  always_comb begin
    req   = '0;
    gnt_d = GNT_NONE;
    if (estop) begin
      gnt_d = GNT_ESTOP;
    end else if (mis_req) begin
      gnt_d = GNT_MIS;
      req   = '{mis_dir, mis_dutyA, mis_dutyB};
    end else if (lf_req) begin
      gnt_d = GNT_LF;
      req   = '{lf_dir, lf_dutyA, lf_dutyB};
    end
    err_d = (gnt_d == GNT_MIS || gnt_d == GNT_LF)
            && dir_illegal(req.dir);
    tgt   = err_d ? '0 : req;
  end

  assign tick = (rcnt_q == RW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= tick ? '0 : rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_COAST;
      dead_q  <= '0;
      grant_q <= GNT_NONE;
      err_q   <= 1'b0;
    end else begin
      grant_q <= gnt_d;
      err_q   <= err_d;
      if (estop) begin
        state_q <= ST_ESTOP;
        dir_q   <= DIR_COAST;
        dead_q  <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (tgt.dir != DIR_COAST) begin
              state_q <= ST_RUN;
              dir_q   <= tgt.dir;
            end
          end
          ST_RUN: begin
            if (tgt.dir == DIR_COAST) begin
              state_q <= ST_IDLE;
              dir_q   <= DIR_COAST;
            end else if (tgt.dir != dir_q) begin
              state_q <= ST_DEAD;
              dir_q   <= DIR_COAST;
              dead_q  <= '0;
            end
          end
          ST_DEAD: begin
            // Last dead cycle hands straight to RUN if asked.
            if (dead_q == DW'(DEADTIME_CYC - 1)) begin
              dead_q <= '0;
              if (tgt.dir != DIR_COAST) begin
                state_q <= ST_RUN;
                dir_q   <= tgt.dir;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              dead_q <= dead_q + 1'b1;
            end
          end
          ST_ESTOP: begin
            state_q <= ST_DEAD;
            dead_q  <= '0;
          end
          default: begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_COAST;
          end
        endcase
      end
    end
  end

  assign hold = (state_q == ST_RUN) && (tgt.dir == dir_q)
                && !estop;

  duty_ramp #(.STEP(RAMP_STEP)) u_ramp_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .clear  (!hold),
    .target (tgt.duty_a),
    .duty   (DutyA)
  );

  duty_ramp #(.STEP(RAMP_STEP)) u_ramp_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .clear  (!hold),
    .target (tgt.duty_b),
    .duty   (DutyB)
  );

  assign Direction = dir_q;
  assign grant     = grant_q;
  assign dir_err   = err_q;

endmodule
